// File: rtl/cpu_dbg_pkg.sv
// Shared debug package for the CPU trace logic.
//  - Trace FSM state encodings (IDLE/ARMED/RUN/DONE), exposed on the state port.
//  - Trace entry layout: 64 bits, pc in [63:32], alu_result in [31:0].
//  - Helper function that packs one {pc, alu_result} sample into an entry.
package cpu_dbg_pkg;

  localparam int TRACE_W = 64;

  localparam logic [1:0] TRC_IDLE  = 2'd0;
  localparam logic [1:0] TRC_ARMED = 2'd1;
  localparam logic [1:0] TRC_RUN   = 2'd2;
  localparam logic [1:0] TRC_DONE  = 2'd3;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] result;
  } trace_entry_t;

  function automatic trace_entry_t pack_entry(input logic [31:0] pc_in,
                                              input logic [31:0] result_in);
    trace_entry_t e;
    e.pc     = pc_in;
    e.result = result_in;
    return e;
  endfunction

endpackage

// File: rtl/trace_ram.sv
// Trace storage: DEPTH x TRACE_W words, synchronous write, asynchronous read.
// Ports:
//  clk    in   1             write clock
//  we     in   1             write enable
//  waddr  in   $clog2(DEPTH) write address
//  wdata  in   TRACE_W       write data
//  raddr  in   $clog2(DEPTH) read address
//  rdata  out  TRACE_W       combinational read of mem[raddr]
// Contents are intentionally not reset.
module trace_ram
  import cpu_dbg_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [TRACE_W-1:0]       wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [TRACE_W-1:0]       rdata
);

  logic [TRACE_W-1:0] mem [DEPTH];

  // Synchronous write port.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/cpu_trace_buffer.sv
// Passive trace recorder for the cpu_top result interface.
// Once armed, waits for pc == trig_pc, then records one {pc, alu_result}
// entry per new pc value into a circular buffer drained over a valid/ready port.
// Ports:
//  clk, rst            clock, synchronous active-high reset
//  pc, alu_result      observed core outputs, sampled every cycle
//  arm                 pulse: flush, clear overflow, enter ARMED (highest priority)
//  stop                pulse: RUN -> DONE (ignored in other states)
//  trig_pc             pc value that starts capture
//  rd_ready            reader accepts head entry
//  rd_valid            head entry available
//  rd_pc, rd_result    head entry fields (meaningless while rd_valid = 0)
//  level               entries held, 0..DEPTH
//  overflow            sticky: an entry was dropped or overwritten
//  state               IDLE=0, ARMED=1, RUN=2, DONE=3
// WRAP = 0 stops capture when the buffer fills; WRAP = 1 overwrites the oldest entry.
module cpu_trace_buffer
  import cpu_dbg_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter bit WRAP  = 1'b0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [31:0]              pc,
  input  logic [31:0]              alu_result,
  input  logic                     arm,
  input  logic                     stop,
  input  logic [31:0]              trig_pc,
  input  logic                     rd_ready,
  output logic                     rd_valid,
  output logic [31:0]              rd_pc,
  output logic [31:0]              rd_result,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow,
  output logic [1:0]               state
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] LEVEL_FULL = LW'(DEPTH);

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [31:0]   last_pc;
  logic          first;

  logic [AW-1:0] wr_ptr_n;
  logic [AW-1:0] rd_ptr_n;
  logic [LW-1:0] level_n;
  logic          overflow_n;
  logic [1:0]    state_n;
  logic [31:0]   last_pc_n;
  logic          first_n;

  logic          trig_hit;
  logic          push;
  logic          pop;
  logic          full;
  logic          we;
  trace_entry_t  wr_entry;
  trace_entry_t  rd_entry;

  assign trig_hit = (pc == trig_pc);
  assign full     = (level == LEVEL_FULL);
  assign rd_valid = (level != {LW{1'b0}});
  assign pop      = rd_valid & rd_ready;
  // The trigger sample itself is captured, so ARMED+hit counts as a capture cycle.
  assign push     = ((state == TRC_RUN) || ((state == TRC_ARMED) && trig_hit)) &&
                    (first || (pc != last_pc));
  assign wr_entry = pack_entry(pc, alu_result);

  trace_ram #(.DEPTH(DEPTH)) u_ram (
    .clk   (clk),
    .we    (we),
    .waddr (wr_ptr),
    .wdata (wr_entry),
    .raddr (rd_ptr),
    .rdata (rd_entry)
  );

  assign rd_pc     = rd_entry.pc;
  assign rd_result = rd_entry.result;

  // Next-state logic for FSM, pointers, level, change detect and overflow.
  always_comb begin
    wr_ptr_n   = wr_ptr;
    rd_ptr_n   = rd_ptr;
    level_n    = level;
    overflow_n = overflow;
    state_n    = state;
    last_pc_n  = last_pc;
    first_n    = first;
    we         = 1'b0;
    if (arm) begin
      // Flush discards any unread entries and restarts change detection.
      wr_ptr_n   = {AW{1'b0}};
      rd_ptr_n   = {AW{1'b0}};
      level_n    = {LW{1'b0}};
      overflow_n = 1'b0;
      first_n    = 1'b1;
      state_n    = TRC_ARMED;
    end else begin
      if (push) begin
        last_pc_n = pc;
        first_n   = 1'b0;
        if (!full || pop) begin
          we       = 1'b1;
          wr_ptr_n = wr_ptr + AW'(1);
          if (pop) begin
            rd_ptr_n = rd_ptr + AW'(1);
          end else begin
            level_n = level + LW'(1);
          end
        end else if (WRAP) begin
          // Overwrite the oldest entry: head moves along with the tail.
          we         = 1'b1;
          wr_ptr_n   = wr_ptr + AW'(1);
          rd_ptr_n   = rd_ptr + AW'(1);
          overflow_n = 1'b1;
        end else begin
          overflow_n = 1'b1;
        end
      end else if (pop) begin
        rd_ptr_n = rd_ptr + AW'(1);
        level_n  = level - LW'(1);
      end else begin
        level_n = level;
      end

      case (state)
        TRC_ARMED: state_n = trig_hit ? TRC_RUN : TRC_ARMED;
        TRC_RUN:   state_n = stop ? TRC_DONE : TRC_RUN;
        TRC_IDLE:  state_n = TRC_IDLE;
        TRC_DONE:  state_n = TRC_DONE;
        default:   state_n = TRC_IDLE;
      endcase

      // Auto-stop is evaluated after the push that fills the buffer.
      if (!WRAP && push && (level != LEVEL_FULL) && (level_n == LEVEL_FULL)) begin
        state_n = TRC_DONE;
      end else begin
        state_n = state_n;
      end
    end
  end

  // State registers with synchronous reset; memory contents are not reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= {AW{1'b0}};
      rd_ptr   <= {AW{1'b0}};
      level    <= {LW{1'b0}};
      overflow <= 1'b0;
      state    <= TRC_IDLE;
      last_pc  <= 32'h0000_0000;
      first    <= 1'b1;
    end else begin
      wr_ptr   <= wr_ptr_n;
      rd_ptr   <= rd_ptr_n;
      level    <= level_n;
      overflow <= overflow_n;
      state    <= state_n;
      last_pc  <= last_pc_n;
      first    <= first_n;
    end
  end

endmodule

// File: tb/tb_cpu_trace_buffer.sv
// Directed bench for cpu_trace_buffer: three instances share clock, reset and the
// observed pc/alu_result bus; each has its own arm/stop/rd_ready so only the
// instance under test is active. alu_result is always driven as pc + 0x1000.
module tb_cpu_trace_buffer;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc;
  logic [31:0] alu_result;
  logic [31:0] trig_pc;

  logic        arm_a, stop_a, rdy_a, vld_a, ovf_a;
  logic [31:0] rpc_a, rres_a;
  logic [4:0]  lvl_a;
  logic [1:0]  st_a;

  logic        arm_b, stop_b, rdy_b, vld_b, ovf_b;
  logic [31:0] rpc_b, rres_b;
  logic [2:0]  lvl_b;
  logic [1:0]  st_b;

  logic        arm_c, stop_c, rdy_c, vld_c, ovf_c;
  logic [31:0] rpc_c, rres_c;
  logic [2:0]  lvl_c;
  logic [1:0]  st_c;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  cpu_trace_buffer #(.DEPTH(16), .WRAP(1'b0)) dut_a (
    .clk(clk), .rst(rst), .pc(pc), .alu_result(alu_result), .arm(arm_a), .stop(stop_a),
    .trig_pc(trig_pc), .rd_ready(rdy_a), .rd_valid(vld_a), .rd_pc(rpc_a),
    .rd_result(rres_a), .level(lvl_a), .overflow(ovf_a), .state(st_a));

  cpu_trace_buffer #(.DEPTH(4), .WRAP(1'b0)) dut_b (
    .clk(clk), .rst(rst), .pc(pc), .alu_result(alu_result), .arm(arm_b), .stop(stop_b),
    .trig_pc(trig_pc), .rd_ready(rdy_b), .rd_valid(vld_b), .rd_pc(rpc_b),
    .rd_result(rres_b), .level(lvl_b), .overflow(ovf_b), .state(st_b));

  cpu_trace_buffer #(.DEPTH(4), .WRAP(1'b1)) dut_c (
    .clk(clk), .rst(rst), .pc(pc), .alu_result(alu_result), .arm(arm_c), .stop(stop_c),
    .trig_pc(trig_pc), .rd_ready(rdy_c), .rd_valid(vld_c), .rd_pc(rpc_c),
    .rd_result(rres_c), .level(lvl_c), .overflow(ovf_c), .state(st_c));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] p);
    pc         = p;
    alu_result = p + 32'h0000_1000;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; trig_pc = 32'h0; drive(32'h0);
    arm_a = 1'b0; stop_a = 1'b0; rdy_a = 1'b0;
    arm_b = 1'b0; stop_b = 1'b0; rdy_b = 1'b0;
    arm_c = 1'b0; stop_c = 1'b0; rdy_c = 1'b0;

    // 1. reset
    tick(); tick(); tick();
    rst = 1'b0;
    tick();
    chk("rst_state_a", 32'(st_a), 32'd0);
    chk("rst_level_a", 32'(lvl_a), 32'd0);
    chk("rst_valid_a", 32'(vld_a), 32'd0);
    chk("rst_ovf_a",   32'(ovf_a), 32'd0);
    chk("rst_state_c", 32'(st_c), 32'd0);
    chk("rst_level_c", 32'(lvl_c), 32'd0);

    // stop outside RUN is ignored
    stop_a = 1'b1; tick(); stop_a = 1'b0;
    chk("idle_stop_ignored", 32'(st_a), 32'd0);

    // 2. basic capture with change detect
    trig_pc = 32'h8;
    arm_a = 1'b1; tick(); arm_a = 1'b0;
    chk("armed_a", 32'(st_a), 32'd1);
    drive(32'h0); tick();
    drive(32'h4); tick();
    chk("pre_trig_level", 32'(lvl_a), 32'd0);
    chk("pre_trig_state", 32'(st_a), 32'd1);
    drive(32'h8); tick();
    chk("trig_state", 32'(st_a), 32'd2);
    chk("trig_level", 32'(lvl_a), 32'd1);
    chk("trig_valid", 32'(vld_a), 32'd1);
    chk("trig_rd_pc", rpc_a, 32'h8);
    drive(32'hC); tick();
    drive(32'hC); tick();
    drive(32'h10); tick();
    chk("t2_level", 32'(lvl_a), 32'd3);
    stop_a = 1'b1; tick(); stop_a = 1'b0;
    chk("t2_stop_done", 32'(st_a), 32'd3);
    rdy_a = 1'b1;
    chk("t2_pop0_pc",  rpc_a,  32'h8);
    chk("t2_pop0_res", rres_a, 32'h1008);
    tick();
    chk("t2_pop1_pc",  rpc_a,  32'hC);
    chk("t2_pop1_res", rres_a, 32'h100C);
    tick();
    chk("t2_pop2_pc",  rpc_a,  32'h10);
    chk("t2_pop2_res", rres_a, 32'h1010);
    tick();
    rdy_a = 1'b0;
    chk("t2_empty_level", 32'(lvl_a), 32'd0);
    chk("t2_empty_valid", 32'(vld_a), 32'd0);

    // 3. DEPTH=4 WRAP=0 auto-stop at full
    trig_pc = 32'h200;
    arm_b = 1'b1; tick(); arm_b = 1'b0;
    drive(32'h200); tick();
    drive(32'h204); tick();
    drive(32'h208); tick();
    chk("t3_run_before_full", 32'(st_b), 32'd2);
    drive(32'h20C); tick();
    chk("t3_done_at_full", 32'(st_b), 32'd3);
    drive(32'h210); tick();
    drive(32'h214); tick();
    chk("t3_level", 32'(lvl_b), 32'd4);
    chk("t3_ovf",   32'(ovf_b), 32'd0);
    rdy_b = 1'b1;
    chk("t3_rd0", rpc_b, 32'h200);
    chk("t3_res0", rres_b, 32'h1200);
    tick(); chk("t3_rd1", rpc_b, 32'h204);
    tick(); chk("t3_rd2", rpc_b, 32'h208);
    tick(); chk("t3_rd3", rpc_b, 32'h20C);
    chk("t3_res3", rres_b, 32'h120C);
    tick(); rdy_b = 1'b0;
    chk("t3_drained", 32'(vld_b), 32'd0);

    // 4. DEPTH=4 WRAP=1 overwrite oldest
    trig_pc = 32'h100;
    arm_c = 1'b1; tick(); arm_c = 1'b0;
    drive(32'h100); tick();
    drive(32'h104); tick();
    drive(32'h108); tick();
    drive(32'h10C); tick();
    chk("t4_full_ovf0", 32'(ovf_c), 32'd0);
    drive(32'h110); tick();
    drive(32'h114); tick();
    chk("t4_level", 32'(lvl_c), 32'd4);
    chk("t4_ovf",   32'(ovf_c), 32'd1);
    chk("t4_state", 32'(st_c), 32'd2);
    stop_c = 1'b1; tick(); stop_c = 1'b0;
    rdy_c = 1'b1;
    chk("t4_rd0", rpc_c, 32'h108);
    tick(); chk("t4_rd1", rpc_c, 32'h10C);
    tick(); chk("t4_rd2", rpc_c, 32'h110);
    tick(); chk("t4_rd3", rpc_c, 32'h114);
    chk("t4_res3", rres_c, 32'h1114);
    tick(); rdy_c = 1'b0;
    chk("t4_drained", 32'(lvl_c), 32'd0);

    // 5. full with simultaneous push and pop
    trig_pc = 32'h300;
    arm_c = 1'b1; tick(); arm_c = 1'b0;
    chk("t5_arm_clears_ovf", 32'(ovf_c), 32'd0);
    drive(32'h300); tick();
    drive(32'h304); tick();
    drive(32'h308); tick();
    drive(32'h30C); tick();
    chk("t5_full", 32'(lvl_c), 32'd4);
    drive(32'h310); rdy_c = 1'b1;
    chk("t5_popped_oldest", rpc_c, 32'h300);
    tick(); rdy_c = 1'b0;
    chk("t5_level", 32'(lvl_c), 32'd4);
    chk("t5_ovf",   32'(ovf_c), 32'd0);
    chk("t5_new_head", rpc_c, 32'h304);
    stop_c = 1'b1; tick(); stop_c = 1'b0;

    // 6. arm during readout, with simultaneous stop
    trig_pc = 32'h400;
    arm_a = 1'b1; tick(); arm_a = 1'b0;
    drive(32'h400); tick();
    drive(32'h404); tick();
    drive(32'h408); tick();
    chk("t6_level3", 32'(lvl_a), 32'd3);
    rdy_a = 1'b1; arm_a = 1'b1; stop_a = 1'b1;
    tick();
    arm_a = 1'b0; stop_a = 1'b0;
    chk("t6_level0", 32'(lvl_a), 32'd0);
    chk("t6_valid0", 32'(vld_a), 32'd0);
    chk("t6_armed",  32'(st_a), 32'd1);
    tick(); rdy_a = 1'b0;
    chk("t6_still_armed", 32'(st_a), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
